restoring_div_arbiter: RTL and testbench

//  Shares one sequential restoring-division datapath (2W-bit dividend / W-bit divisor) among NREQ requesters.

---
 rtl/restoring_div_arbiter_if.sv | 48 ++++
 rtl/restoring_div_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_restoring_div_arbiter.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/restoring_div_arbiter_if.sv
// Request/response bundle for the shared restoring divider.
// master = client side, slave = divider side.
interface restoring_div_arbiter_if #(
    parameter int NREQ = 4,
    parameter int W    = 4
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*2*W-1:0] req_dividend;
    logic [NREQ*W-1:0]   req_divisor;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [W-1:0]        rsp_quotient;
    logic [W-1:0]        rsp_remainder;
    logic                rsp_err;
    logic                busy;

    modport master (
        output req_valid,
        output req_dividend,
        output req_divisor,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_id,
        input  rsp_quotient,
        input  rsp_remainder,
        input  rsp_err,
        input  busy
    );

    modport slave (
        input  req_valid,
        input  req_dividend,
        input  req_divisor,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_id,
        output rsp_quotient,
        output rsp_remainder,
        output rsp_err,
        output busy
    );
endinterface

// File: rtl/restoring_div_arbiter.sv
// Round-robin shared restoring divider (2W/W), one quotient bit per cycle.
// Optional RDIV_STATS_EN adds saturating op/error counters.
module restoring_div_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 4
) (
    input  logic clk,
    input  logic rst_n,
    restoring_div_arbiter_if.slave bus
`ifdef RDIV_STATS_EN
    ,
    output logic [15:0] stat_ops,
    output logic [15:0] stat_errs
`endif
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW  = $clog2(W + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [IDW-1:0] r_rr_ptr;
    logic [IDW-1:0] r_id;
    logic [W-1:0]   r_dvs;
    logic [W-1:0]   r_lo;
    logic [W-1:0]   r_p;
    logic [W-1:0]   r_q;
    logic           r_err;
    logic [CW-1:0]  r_cnt;

    logic           w_found;
    logic [IDW-1:0] w_grant;
    logic [IDW-1:0] w_idx;
    logic [NREQ-1:0] w_ready;
    logic           w_hs;
    logic           w_rsp_hs;
    logic [2*W-1:0] w_sel_dvd;
    logic [W-1:0]   w_sel_dvs;
    logic           w_err;
    logic [W:0]     w_sh;
    logic [W:0]     w_t;

    // Cyclic search for the first valid requester starting at rr_ptr
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = IDW'((int'(r_rr_ptr) + k) % NREQ);
            if (!w_found && bus.req_valid[w_idx]) begin
                w_found = 1'b1;
                w_grant = w_idx;
            end
        end
    end

    // Ready only toward the granted requester, only while idle
    always_comb begin
        w_ready = '0;
        if (rst_n && r_state == S_IDLE && w_found) begin
            w_ready[w_grant] = 1'b1;
        end
    end

    assign w_hs      = rst_n && (r_state == S_IDLE) && w_found;
    assign w_rsp_hs  = (r_state == S_DONE) && bus.rsp_ready;
    assign w_sel_dvd = bus.req_dividend[w_grant*2*W +: 2*W];
    assign w_sel_dvs = bus.req_divisor[w_grant*W +: W];
    // Zero divisor is covered too: any high half is >= 0
    assign w_err     = (w_sel_dvd[2*W-1:W] >= w_sel_dvs);

    // Shift in the next dividend bit and trial-subtract the divisor
    assign w_sh = {r_p, r_lo[W-1]};
    assign w_t  = w_sh - {1'b0, r_dvs};

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_hs) begin
                    w_next = w_err ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt == CW'(1)) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Operand capture, arbitration pointer and divider iteration
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
            r_id     <= '0;
            r_dvs    <= '0;
            r_lo     <= '0;
            r_p      <= '0;
            r_q      <= '0;
            r_err    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_hs) begin
                        r_id     <= w_grant;
                        r_rr_ptr <= (w_grant == IDW'(NREQ - 1)) ? '0
                                    : w_grant + 1'b1;
                        r_dvs    <= w_sel_dvs;
                        r_lo     <= w_sel_dvd[W-1:0];
                        r_cnt    <= CW'(W);
                        if (w_err) begin
                            r_err <= 1'b1;
                            r_q   <= '1;
                            r_p   <= '0;
                        end else begin
                            r_err <= 1'b0;
                            r_q   <= '0;
                            r_p   <= w_sel_dvd[2*W-1:W];
                        end
                    end
                end
                S_RUN: begin
                    r_lo  <= r_lo << 1;
                    r_cnt <= r_cnt - 1'b1;
                    if (!w_t[W]) begin
                        r_p <= w_t[W-1:0];
                        r_q <= {r_q[W-2:0], 1'b1};
                    end else begin
                        r_p <= w_sh[W-1:0];
                        r_q <= {r_q[W-2:0], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef RDIV_STATS_EN
    logic [15:0] r_stat_ops;
    logic [15:0] r_stat_errs;

    // Saturating counters of completed responses and error responses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stat_ops  <= '0;
            r_stat_errs <= '0;
        end else if (w_rsp_hs) begin
            if (r_stat_ops != 16'hFFFF) begin
                r_stat_ops <= r_stat_ops + 16'd1;
            end
            if (r_err && r_stat_errs != 16'hFFFF) begin
                r_stat_errs <= r_stat_errs + 16'd1;
            end
        end
    end

    assign stat_ops  = r_stat_ops;
    assign stat_errs = r_stat_errs;
`else
    logic w_unused;
    assign w_unused = w_rsp_hs;
`endif

    assign bus.req_ready     = w_ready;
    assign bus.rsp_valid     = (r_state == S_DONE);
    assign bus.rsp_id        = r_id;
    assign bus.rsp_quotient  = r_q;
    assign bus.rsp_remainder = r_p;
    assign bus.rsp_err       = r_err;
    assign bus.busy          = (r_state != S_IDLE);
endmodule

// File: tb/tb_restoring_div_arbiter.sv
// Directed bench for restoring_div_arbiter (NREQ=4, W=4).
// Build with RDIV_STATS_EN defined to also check the statistics counters.
module tb_restoring_div_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    restoring_div_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

`ifdef RDIV_STATS_EN
    logic [15:0] stat_ops;
    logic [15:0] stat_errs;
`endif

    restoring_div_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus)
`ifdef RDIV_STATS_EN
        ,
        .stat_ops (stat_ops),
        .stat_errs(stat_errs)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int id, input logic [7:0] dvd,
                         input logic [3:0] dvs);
        bus.req_valid[id]           = 1'b1;
        bus.req_dividend[id*8 +: 8] = dvd;
        bus.req_divisor[id*4 +: 4]  = dvs;
    endtask

    // Called at a negedge; returns at the negedge after the accept edge
    task automatic accept(input int id, input logic [7:0] dvd,
                          input logic [3:0] dvs);
        int n = 0;
        drive(id, dvd, dvs);
        #1;
        while (!bus.req_ready[id] && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("accept_ready", 32'(bus.req_ready[id]), 1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid[id] = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!bus.rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic pop();
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic check_rsp(input string tag, input int id, input int q,
                             input int r, input int err);
        chk({tag, "_valid"}, 32'(bus.rsp_valid), 1);
        chk({tag, "_id"}, 32'(bus.rsp_id), 32'(id));
        chk({tag, "_q"}, 32'(bus.rsp_quotient), 32'(q));
        chk({tag, "_r"}, 32'(bus.rsp_remainder), 32'(r));
        chk({tag, "_err"}, 32'(bus.rsp_err), 32'(err));
    endtask

    int lat;
    int exp_q[4] = '{2, 4, 5, 7};
    int exp_r[4] = '{6, 2, 5, 1};
    logic seen;
    logic [3:0] onehot;

    initial begin
        bus.req_valid    = '0;
        bus.req_dividend = '0;
        bus.req_divisor  = '0;
        bus.rsp_ready    = 1'b0;
        rst_n            = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_valid", 32'(bus.rsp_valid), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_ready", 32'(bus.req_ready), 0);
        chk("rst_q", 32'(bus.rsp_quotient), 0);
        chk("rst_r", 32'(bus.rsp_remainder), 0);
        chk("rst_id", 32'(bus.rsp_id), 0);
        chk("rst_err", 32'(bus.rsp_err), 0);
`ifdef RDIV_STATS_EN
        chk("rst_stat_ops", 32'(stat_ops), 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // 100 / 7 = 14 r 2
        accept(0, 8'd100, 4'd7);
        chk("t1_busy", 32'(bus.busy), 1);
        wait_rsp(lat);
        chk("t1_latency", 32'(lat), 5);
        check_rsp("t1", 0, 14, 2, 0);
        pop();
        chk("t1_idle", 32'(bus.busy), 0);

        // 200 / 5 overflows the 4-bit quotient
        accept(1, 8'd200, 4'd5);
        wait_rsp(lat);
        chk("t2_latency", 32'(lat), 1);
        check_rsp("t2ovf", 1, 15, 0, 1);
        pop();

        // 9 / 0
        accept(1, 8'd9, 4'd0);
        wait_rsp(lat);
        chk("t2z_latency", 32'(lat), 1);
        check_rsp("t2zero", 1, 15, 0, 1);
        pop();
`ifdef RDIV_STATS_EN
        chk("stat_ops", 32'(stat_ops), 3);
        chk("stat_errs", 32'(stat_errs), 2);
`endif

        // Zero dividend is a normal operation
        accept(3, 8'd0, 4'd3);
        wait_rsp(lat);
        chk("zd_latency", 32'(lat), 5);
        check_rsp("zd", 3, 0, 0, 0);
        pop();

        // All four requesters valid: rr_ptr wrapped to 0
        for (int i = 0; i < 4; i++) begin
            drive(i, 8'(20 + 10 * i), 4'd7);
        end
        for (int k = 0; k < 5; k++) begin
            #1;
            onehot = 4'b0001 << (k % 4);
            chk("rr_count", 32'($countones(bus.req_ready)), 1);
            chk("rr_grant", 32'(bus.req_ready), 32'(onehot));
            @(posedge clk);
            @(negedge clk);
            chk("rr_busy_ready", 32'(bus.req_ready), 0);
            wait_rsp(lat);
            check_rsp("rr", k % 4, exp_q[k%4], exp_r[k%4], 0);
            pop();
        end
        bus.req_valid = '0;

        // Backpressure: response held, no grant while in DONE
        accept(2, 8'd45, 4'd6);
        wait_rsp(lat);
        drive(0, 8'd50, 4'd7);
        for (int c = 0; c < 3; c++) begin
            #1;
            check_rsp("bp", 2, 7, 3, 0);
            chk("bp_ready", 32'(bus.req_ready), 0);
            @(negedge clk);
        end
        pop();
        #1;
        chk("bp_after_ready", 32'(bus.req_ready), 32'h1);
        bus.req_valid = '0;
        @(negedge clk);

        // Reset during RUN aborts the operation
        accept(1, 8'd100, 4'd7);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mrst_valid", 32'(bus.rsp_valid), 0);
        chk("mrst_busy", 32'(bus.busy), 0);
        chk("mrst_q", 32'(bus.rsp_quotient), 0);
        chk("mrst_r", 32'(bus.rsp_remainder), 0);
        chk("mrst_id", 32'(bus.rsp_id), 0);
        chk("mrst_err", 32'(bus.rsp_err), 0);
`ifdef RDIV_STATS_EN
        chk("mrst_stat_ops", 32'(stat_ops), 0);
        chk("mrst_stat_errs", 32'(stat_errs), 0);
`endif
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(i, 8'd10, 4'd3);
        end
        #1;
        chk("mrst_rrptr", 32'(bus.req_ready), 32'h1);
        bus.req_valid = '0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen = seen | bus.rsp_valid;
        end
        chk("mrst_no_stale", 32'(seen), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
